v_issue_queue: RTL and testbench

V_ISSUE_QUEUE -- requirements
Module: v_issue_queue

---
 rtl/v_pkg.sv | 10 +
 rtl/v_instr_fifo.sv | 39 +++
 rtl/v_issue_queue.sv | 86 ++++++++
 tb/tb_v_issue_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// v_pkg: shared FSM state type, vector opcode constants and the vsetvli/vsetivli decode helper.
// Contents: state_t (IDLE, BUSY, BUBBLE), OPC_VECTOR, F3_OPCFG, is_cfg().
package v_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, BUBBLE} state_t;
    localparam logic [6:0] OPC_VECTOR = 7'b1010111;
    localparam logic [2:0] F3_OPCFG   = 3'b111;
    function automatic logic is_cfg(input logic [31:0] instr);
        return instr[6:0] == OPC_VECTOR && instr[14:12] == F3_OPCFG;
    endfunction
endpackage

// File: rtl/v_instr_fifo.sv
// v_instr_fifo: circular buffer of {instr, rs1, rs2} entries feeding the issue FSM.
// Ports: clk, nrst (async active-low); push/pop/clear controls; din/dout 96-bit entry;
//        count = occupied entries.
module v_instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  logic [95:0]             din,
    output logic [95:0]             dout,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    // Power-of-two depth lets the pointers wrap DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/v_issue_queue.sv
// v_issue_queue: queues vector instructions from the scalar core and issues them one at a
// time to the coprocessor, with a one-cycle NOP bubble after each and a completion watchdog.
// Ports: clk, nrst (async active-low); enq_valid/enq_ready/enq_instr/enq_rs1/enq_rs2 input
//        handshake; issue_valid/issue_instr/issue_rs1/issue_rs2 to the coprocessor;
//        unit_done completion; flush discard; count occupancy; busy; err_timeout sticky flag.
module v_issue_queue
    import v_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [31:0]             enq_instr,
    input  logic [31:0]             enq_rs1,
    input  logic [31:0]             enq_rs2,
    output logic                    issue_valid,
    output logic [31:0]             issue_instr,
    output logic [31:0]             issue_rs1,
    output logic [31:0]             issue_rs2,
    input  logic                    unit_done,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic [95:0]   head, cur;
    logic [WW-1:0] wd;
    logic          push, pop, wd_hit;
    assign enq_ready   = (count < (AW+1)'(DEPTH)) & ~flush;
    assign push        = enq_valid & enq_ready;
    assign pop         = state == IDLE && count != '0 && !flush;
    // wd counts completed BUSY cycles, so the TIMEOUT-th BUSY cycle is the one with wd == TIMEOUT-1.
    assign wd_hit      = wd == WW'(TIMEOUT - 1);
    // Outputs are gated by state so async reset and the BUBBLE cycle both present a NOP at once.
    assign issue_valid = state == BUSY;
    assign issue_instr = issue_valid ? cur[95:64] : '0;
    assign issue_rs1   = issue_valid ? cur[63:32] : '0;
    assign issue_rs2   = issue_valid ? cur[31:0]  : '0;
    assign busy        = state != IDLE || count != '0;
    v_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({enq_instr, enq_rs1, enq_rs2}),
        .dout  (head),
        .count (count)
    );
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cur         <= '0;
            wd          <= '0;
            err_timeout <= 1'b0;
        end else if (flush) begin
            state       <= BUBBLE;
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state <= BUSY;
                    cur   <= head;
                    wd    <= '0;
                end
                BUSY: begin
                    wd <= wd + 1'b1;
                    if (is_cfg(cur[95:64]) || unit_done) begin
                        state <= BUBBLE;
                    end else if (wd_hit) begin
                        state       <= BUBBLE;
                        err_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v_issue_queue.sv
// tb_v_issue_queue: table-driven directed checks of v_issue_queue plus hand-written
// timeout and asynchronous-reset sequences.
module tb_v_issue_queue;
    localparam logic [31:0] VADD = 32'h02208057;
    localparam logic [31:0] VSET = 32'h0D007057;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enq_valid = 1'b0, unit_done = 1'b0, flush = 1'b0;
    logic [31:0] enq_instr = '0, enq_rs1 = '0, enq_rs2 = '0;
    logic        enq_ready, issue_valid, busy, err_timeout;
    logic [31:0] issue_instr, issue_rs1, issue_rs2;
    logic [2:0]  count;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    v_issue_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .nrst(nrst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_instr(enq_instr), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .unit_done(unit_done), .flush(flush),
        .count(count), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic        ev;
        logic [31:0] instr, rs1;
        logic        ud, fl;
        logic        x_iv;
        logic [31:0] x_instr, x_rs1;
        logic [2:0]  x_cnt;
        logic        x_busy, x_rdy, x_err;
    } vec_t;

    function automatic vec_t mk(logic ev, logic [31:0] instr, logic [31:0] rs1, logic ud, logic fl,
                                logic x_iv, logic [31:0] x_instr, logic [31:0] x_rs1,
                                logic [2:0] x_cnt, logic x_busy, logic x_rdy, logic x_err);
        vec_t v;
        v.ev = ev; v.instr = instr; v.rs1 = rs1; v.ud = ud; v.fl = fl;
        v.x_iv = x_iv; v.x_instr = x_instr; v.x_rs1 = x_rs1;
        v.x_cnt = x_cnt; v.x_busy = x_busy; v.x_rdy = x_rdy; v.x_err = x_err;
        return v;
    endfunction

    function automatic logic [31:0] a(int i);
        return VADD + 32'(i << 7);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(logic ev, logic [31:0] instr, logic [31:0] rs1, logic ud, logic fl);
        @(negedge clk);
        enq_valid = ev; enq_instr = instr; enq_rs1 = rs1; enq_rs2 = rs1 + 1;
        unit_done = ud; flush = fl;
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // REQ-036 single vadd
        vecs.push_back(mk(1, VADD, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, VADD, 5, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, VADD, 5, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // REQ-038 vsetvli completes after one BUSY cycle without unit_done
        vecs.push_back(mk(1, VSET, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, VSET, 7, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // REQ-037 back-to-back enqueue until full
        vecs.push_back(mk(1, a(1), 16, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, a(2), 32, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, a(3), 48, 0, 0, 1, a(1), 16, 1, 1, 1, 0));
        vecs.push_back(mk(1, a(4), 64, 0, 0, 1, a(1), 16, 2, 1, 1, 0));
        vecs.push_back(mk(1, a(5), 80, 0, 0, 1, a(1), 16, 3, 1, 1, 0));
        vecs.push_back(mk(1, a(6), 96, 0, 0, 1, a(1), 16, 4, 1, 0, 0));
        vecs.push_back(mk(1, a(6), 96, 0, 0, 1, a(1), 16, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, a(1), 16, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, a(2), 32, 3, 1, 1, 0));
        // REQ-040 flush in BUSY with count=3 and a same-cycle offer
        vecs.push_back(mk(1, a(6), 96, 0, 1, 1, a(2), 32, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Reset state
        #2;
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_issue_instr", issue_instr, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst_enq_ready", 32'(enq_ready), 1);

        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].instr, vecs[i].rs1, vecs[i].ud, vecs[i].fl);
            chk($sformatf("v%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].x_iv));
            chk($sformatf("v%0d_issue_instr", i), issue_instr, vecs[i].x_instr);
            chk($sformatf("v%0d_issue_rs1", i), issue_rs1, vecs[i].x_rs1);
            chk($sformatf("v%0d_issue_rs2", i), issue_rs2, vecs[i].x_iv ? vecs[i].x_rs1 + 1 : 32'h0);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].x_cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].x_busy));
            chk($sformatf("v%0d_enq_ready", i), 32'(enq_ready), 32'(vecs[i].x_rdy));
            chk($sformatf("v%0d_err", i), 32'(err_timeout), 32'(vecs[i].x_err));
        end

        // REQ-039 watchdog: T1 never completes, T2 queued behind it
        drive(1, a(9), 32'h100, 0, 0);
        drive(1, a(10), 32'h200, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("to_busy1_valid", 32'(issue_valid), 1);
        chk("to_busy1_instr", issue_instr, a(9));
        chk("to_busy1_count", 32'(count), 1);
        for (int c = 2; c <= 64; c++) drive(0, 0, 0, 0, 0);
        chk("to_busy64_valid", 32'(issue_valid), 1);
        chk("to_busy64_err", 32'(err_timeout), 0);
        drive(0, 0, 0, 0, 0);
        chk("to_bubble_valid", 32'(issue_valid), 0);
        chk("to_bubble_instr", issue_instr, 0);
        chk("to_bubble_err", 32'(err_timeout), 1);
        drive(0, 0, 0, 0, 0);
        chk("to_idle_valid", 32'(issue_valid), 0);
        drive(0, 0, 0, 0, 0);
        chk("to_next_valid", 32'(issue_valid), 1);
        chk("to_next_instr", issue_instr, a(10));
        chk("to_next_rs1", issue_rs1, 32'h200);
        chk("to_next_err_sticky", 32'(err_timeout), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("to_flush_err", 32'(err_timeout), 0);
        chk("to_flush_valid", 32'(issue_valid), 0);
        chk("to_flush_busy", 32'(busy), 1);
        drive(0, 0, 0, 0, 0);
        chk("to_flush_idle_busy", 32'(busy), 0);

        // REQ-041 async reset mid-BUSY with two entries queued
        drive(1, a(11), 32'h300, 0, 0);
        drive(1, a(12), 32'h400, 0, 0);
        drive(1, a(13), 32'h500, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("ar_pre_valid", 32'(issue_valid), 1);
        chk("ar_pre_instr", issue_instr, a(11));
        chk("ar_pre_count", 32'(count), 2);
        #2;
        nrst = 1'b0;
        #1;
        chk("ar_valid", 32'(issue_valid), 0);
        chk("ar_instr", issue_instr, 0);
        chk("ar_rs1", issue_rs1, 0);
        chk("ar_rs2", issue_rs2, 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_err", 32'(err_timeout), 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("ar_release_ready", 32'(enq_ready), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            chk($sformatf("ar_post%0d_valid", k), 32'(issue_valid), 0);
            chk($sformatf("ar_post%0d_busy", k), 32'(busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
